// File: rtl/mem_port_arbiter.sv
// Shares one external memory bus between instruction fetch and the load/store unit.
// One transaction at a time, each with a bus timeout; registered read data and ack pulses.
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | bus free; pick an owner from the pending requests
// S_BUSY | bus_req_o high, wait for bus_ack_i or the timeout
// S_RESP | pulse the owner's ack for one cycle; requests ignored
module mem_port_arbiter #(
   parameter int unsigned MAX_WAIT = 15
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        if_req_i,
   input  logic [31:0] if_addr_i,
   output logic [31:0] if_rdata_o,
   output logic        if_ack_o,
   input  logic        dm_req_i,
   input  logic        dm_we_i,
   input  logic [31:0] dm_addr_i,
   input  logic [31:0] dm_wdata_i,
   output logic [31:0] dm_rdata_o,
   output logic        dm_ack_o,
   output logic        bus_req_o,
   output logic        bus_we_o,
   output logic [31:0] bus_addr_o,
   output logic [31:0] bus_wdata_o,
   input  logic [31:0] bus_rdata_i,
   input  logic        bus_ack_i,
   output logic        stall_o,
   output logic        err_o
);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

   // Counter value in the last BUSY cycle allowed before giving up.
   localparam logic [7:0] LIMIT = 8'(MAX_WAIT - 1);

   state_t      r_state;
   state_t      w_next;
   logic        r_owner;
   logic        r_last;
   logic [7:0]  r_cnt;
   logic        r_we;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [31:0] r_if_rdata;
   logic [31:0] r_dm_rdata;
   logic        r_if_ack;
   logic        r_dm_ack;
   logic        r_err;

   logic        w_grant;
   logic        w_gnt_dm;
   logic        w_ok;
   logic        w_timeout;
   logic        w_done;
   logic        w_bus_req;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) r_state <= S_IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next    = r_state;
      w_grant   = 1'b0;
      w_gnt_dm  = 1'b0;
      w_ok      = 1'b0;
      w_timeout = 1'b0;
      w_bus_req = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (if_req_i || dm_req_i) begin
               w_grant  = 1'b1;
               // DM wins a tie unless it had the previous grant.
               w_gnt_dm = dm_req_i & (~if_req_i | ~r_last);
               w_next   = S_BUSY;
            end
         end
         S_BUSY: begin
            w_bus_req = 1'b1;
            if (bus_ack_i) begin
               w_ok   = 1'b1;
               w_next = S_RESP;
            end else if (r_cnt >= LIMIT) begin
               w_timeout = 1'b1;
               w_next    = S_RESP;
            end
         end
         S_RESP:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
      w_done = w_ok | w_timeout;
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_owner    <= 1'b0;
         r_last     <= 1'b0;
         r_cnt      <= 8'd0;
         r_we       <= 1'b0;
         r_addr     <= 32'd0;
         r_wdata    <= 32'd0;
         r_if_rdata <= 32'd0;
         r_dm_rdata <= 32'd0;
         r_if_ack   <= 1'b0;
         r_dm_ack   <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_if_ack <= w_done & ~r_owner;
         r_dm_ack <= w_done & r_owner;
         if (w_grant) begin
            r_owner <= w_gnt_dm;
            r_last  <= w_gnt_dm;
            r_cnt   <= 8'd0;
            r_addr  <= w_gnt_dm ? dm_addr_i : if_addr_i;
            r_we    <= w_gnt_dm & dm_we_i;
            r_wdata <= w_gnt_dm ? dm_wdata_i : 32'd0;
         end else if (r_state == S_BUSY && !w_done && r_cnt != 8'hFF) begin
            r_cnt <= r_cnt + 8'd1;
         end
         if (w_done) begin
            if (r_owner) r_dm_rdata <= w_ok ? bus_rdata_i : 32'd0;
            else         r_if_rdata <= w_ok ? bus_rdata_i : 32'd0;
         end
         if (w_timeout) r_err <= 1'b1;
      end
   end

   assign bus_req_o   = w_bus_req;
   assign bus_we_o    = r_we;
   assign bus_addr_o  = r_addr;
   assign bus_wdata_o = r_wdata;
   assign if_rdata_o  = r_if_rdata;
   assign dm_rdata_o  = r_dm_rdata;
   assign if_ack_o    = r_if_ack;
   assign dm_ack_o    = r_dm_ack;
   assign err_o       = r_err;
   assign stall_o     = (if_req_i & ~r_if_ack) | (dm_req_i & ~r_dm_ack);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: table of single transactions, hand-written contention and
// reset sequences, then random traffic against a transaction-timing reference model.
module tb_mem_port_arbiter;

   localparam int MAXW = 15;

   logic        clk = 1'b0;
   logic        rst_n_i;
   logic        if_req_i, dm_req_i, dm_we_i, bus_ack_i;
   logic [31:0] if_addr_i, dm_addr_i, dm_wdata_i, bus_rdata_i;
   logic [31:0] if_rdata_o, dm_rdata_o, bus_addr_o, bus_wdata_o;
   logic        if_ack_o, dm_ack_o, bus_req_o, bus_we_o, stall_o, err_o;

   int n_total = 0;
   int n_pass  = 0;

   mem_port_arbiter #(.MAX_WAIT(MAXW)) dut (
      .clk_i(clk), .rst_n_i(rst_n_i),
      .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o), .if_ack_o(if_ack_o),
      .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
      .dm_rdata_o(dm_rdata_o), .dm_ack_o(dm_ack_o),
      .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
      .bus_wdata_o(bus_wdata_o), .bus_rdata_i(bus_rdata_i), .bus_ack_i(bus_ack_i),
      .stall_o(stall_o), .err_o(err_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        ifr;
      logic [31:0] ifa;
      logic        dmr;
      logic        dwe;
      logic [31:0] dma;
      logic [31:0] dwd;
      int          wt;      // bus wait cycles before ack; >= MAXW means never ack
      logic [31:0] bdata;
      logic        exp_own; // 0 = IF, 1 = DM
      logic [31:0] exp_rd;
      logic        exp_err;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s actual=%h required=%h", name, act, exp);
      else             n_pass++;
   endtask

   function automatic vec_t mk(input logic ifr, input logic [31:0] ifa, input logic dmr,
                               input logic dwe, input logic [31:0] dma, input logic [31:0] dwd,
                               input int wt, input logic [31:0] bdata, input logic own,
                               input logic [31:0] rd, input logic er);
      vec_t v;
      v.ifr = ifr; v.ifa = ifa; v.dmr = dmr; v.dwe = dwe; v.dma = dma; v.dwd = dwd;
      v.wt = wt; v.bdata = bdata; v.exp_own = own; v.exp_rd = rd; v.exp_err = er;
      return v;
   endfunction

   task automatic idle_inputs();
      if_req_i = 0; dm_req_i = 0; dm_we_i = 0; bus_ack_i = 0;
      if_addr_i = 0; dm_addr_i = 0; dm_wdata_i = 0; bus_rdata_i = 32'h5A5A_5A5A;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst_n_i = 0;
      idle_inputs();
      repeat (2) @(negedge clk);
      #2 rst_n_i = 1;
      @(negedge clk);
   endtask

   // Runs one transaction from IDLE; must be called right at a falling edge.
   task automatic run_txn(input vec_t v, input string tag);
      int          exp_n;
      logic        own;
      logic [31:0] ea;
      own = v.exp_own;
      if_req_i = v.ifr; if_addr_i = v.ifa;
      dm_req_i = v.dmr; dm_we_i = v.dwe; dm_addr_i = v.dma; dm_wdata_i = v.dwd;
      ea = own ? v.dma : v.ifa;
      exp_n = (v.wt < MAXW) ? v.wt + 2 : MAXW + 1;
      for (int n = 1; n <= exp_n; n++) begin
         @(negedge clk);
         bus_ack_i = 0;
         if (n < exp_n) begin
            chk({tag, ":bus_req"}, 32'(bus_req_o), 32'd1);
            chk({tag, ":bus_addr"}, bus_addr_o, ea);
            chk({tag, ":bus_we"}, 32'(bus_we_o), 32'(own & v.dwe));
            if (own) chk({tag, ":bus_wdata"}, bus_wdata_o, v.dwd);
            chk({tag, ":acks_busy"}, {30'd0, if_ack_o, dm_ack_o}, 32'd0);
            chk({tag, ":stall_busy"}, 32'(stall_o), 32'd1);
            if (n == v.wt + 1) begin
               bus_ack_i = 1;
               bus_rdata_i = v.bdata;
            end
         end else begin
            chk({tag, ":if_ack"}, 32'(if_ack_o), 32'(!own));
            chk({tag, ":dm_ack"}, 32'(dm_ack_o), 32'(own));
            chk({tag, ":rdata"}, own ? dm_rdata_o : if_rdata_o, v.exp_rd);
            chk({tag, ":bus_req_resp"}, 32'(bus_req_o), 32'd0);
            chk({tag, ":err"}, 32'(err_o), 32'(v.exp_err));
            chk({tag, ":stall_resp"}, 32'(stall_o), 32'(own ? v.ifr : v.dmr));
            if_req_i = 0;
            dm_req_i = 0;
         end
      end
      @(negedge clk);
      chk({tag, ":ack_single"}, {30'd0, if_ack_o, dm_ack_o}, 32'd0);
      chk({tag, ":bus_req_idle"}, 32'(bus_req_o), 32'd0);
      chk({tag, ":stall_idle"}, 32'(stall_o), 32'd0);
   endtask

   vec_t tbl[8];

   // Reference model state for the random phase.
   bit          m_act, m_own, m_last, m_err, m_to;
   int          m_g, m_a, m_L, m_free;
   logic [31:0] m_rd, m_bdata, m_addr, m_wd;
   logic        m_we;

   initial begin
      bit exp_busy, exp_ifa, exp_dma;

      rst_n_i = 0;
      idle_inputs();
      repeat (3) @(negedge clk);
      chk("rst:bus_req", 32'(bus_req_o), 32'd0);
      chk("rst:bus_we", 32'(bus_we_o), 32'd0);
      chk("rst:bus_addr", bus_addr_o, 32'd0);
      chk("rst:bus_wdata", bus_wdata_o, 32'd0);
      chk("rst:acks", {30'd0, if_ack_o, dm_ack_o}, 32'd0);
      chk("rst:if_rdata", if_rdata_o, 32'd0);
      chk("rst:dm_rdata", dm_rdata_o, 32'd0);
      chk("rst:err", 32'(err_o), 32'd0);
      chk("rst:stall", 32'(stall_o), 32'd0);
      #2 rst_n_i = 1;
      @(negedge clk);

      // Tie-breaks depend on the previous owner, so the order of rows matters.
      tbl[0] = mk(1, 32'h0000_0010, 0, 0, 0, 0, 0, 32'h0000_0513, 0, 32'h0000_0513, 0);
      tbl[1] = mk(0, 0, 1, 1, 32'h8000_0004, 32'hDEAD_BEEF, 3, 32'hCAFE_0001, 1, 32'hCAFE_0001, 0);
      tbl[2] = mk(1, 32'h0000_0020, 1, 0, 32'h0000_0200, 0, 1, 32'h00A0_0093, 0, 32'h00A0_0093, 0);
      tbl[3] = mk(1, 32'h0000_0024, 1, 0, 32'h0000_0100, 0, 2, 32'h1111_2222, 1, 32'h1111_2222, 0);
      tbl[4] = mk(0, 0, 1, 0, 32'h0000_0104, 0, MAXW - 1, 32'h1234_5678, 1, 32'h1234_5678, 0);
      tbl[5] = mk(0, 0, 1, 0, 32'h0000_0108, 0, 255, 32'h0, 1, 32'h0, 1);
      tbl[6] = mk(1, 32'h0000_0030, 0, 0, 0, 0, 0, 32'h0000_0077, 0, 32'h0000_0077, 1);
      tbl[7] = mk(0, 0, 1, 1, 32'h0000_0300, 32'h0BAD_F00D, 5, 32'h9999_0000, 1, 32'h9999_0000, 1);
      for (int i = 0; i < 8; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

      // Reset between edges in BUSY.
      if_req_i = 1; if_addr_i = 32'h0000_0040;
      @(negedge clk);
      chk("rstbusy:pre_bus_req", 32'(bus_req_o), 32'd1);
      #2 rst_n_i = 0;
      #1;
      chk("rstbusy:bus_req", 32'(bus_req_o), 32'd0);
      chk("rstbusy:bus_addr", bus_addr_o, 32'd0);
      chk("rstbusy:bus_we", 32'(bus_we_o), 32'd0);
      chk("rstbusy:bus_wdata", bus_wdata_o, 32'd0);
      chk("rstbusy:err", 32'(err_o), 32'd0);
      chk("rstbusy:if_rdata", if_rdata_o, 32'd0);
      chk("rstbusy:dm_rdata", dm_rdata_o, 32'd0);
      chk("rstbusy:acks", {30'd0, if_ack_o, dm_ack_o}, 32'd0);
      chk("rstbusy:stall", 32'(stall_o), 32'd1);
      if_req_i = 0;
      @(negedge clk);
      #2 rst_n_i = 1;
      @(negedge clk);
      run_txn(mk(1, 32'h0000_0044, 0, 0, 0, 0, 1, 32'h0040_0113, 0, 32'h0040_0113, 0), "after_rst");

      // Contention: both held; previous owner is IF, so order is DM, IF, DM, IF.
      if_req_i = 1; if_addr_i = 32'h0000_1000;
      dm_req_i = 1; dm_we_i = 0; dm_addr_i = 32'h0000_2000;
      for (int n = 1; n <= 12; n++) begin
         @(negedge clk);
         bus_ack_i = 0;
         case (n % 3)
            1: begin
               chk($sformatf("cont%0d:bus_req", n), 32'(bus_req_o), 32'd1);
               chk($sformatf("cont%0d:owner_addr", n), bus_addr_o,
                   (((n - 1) / 3) % 2 == 0) ? 32'h0000_2000 : 32'h0000_1000);
               bus_ack_i = 1;
               bus_rdata_i = 32'hC000_0000 + 32'(n);
            end
            2: begin
               chk($sformatf("cont%0d:bus_req_resp", n), 32'(bus_req_o), 32'd0);
               chk($sformatf("cont%0d:acks", n), {30'd0, if_ack_o, dm_ack_o},
                   (((n - 2) / 3) % 2 == 0) ? 32'd1 : 32'd2);
               chk($sformatf("cont%0d:rdata", n),
                   (((n - 2) / 3) % 2 == 0) ? dm_rdata_o : if_rdata_o, 32'hC000_0000 + 32'(n - 1));
            end
            default: begin
               chk($sformatf("cont%0d:no_grant_in_resp", n), 32'(bus_req_o), 32'd0);
               chk($sformatf("cont%0d:acks_idle", n), {30'd0, if_ack_o, dm_ack_o}, 32'd0);
            end
         endcase
      end
      if_req_i = 0; dm_req_i = 0;

      // Random traffic against the transaction-timing model.
      apply_reset();
      m_act = 0; m_last = 0; m_err = 0; m_free = 0; m_own = 0; m_to = 0;
      m_g = 0; m_a = 0; m_L = 0; m_rd = 0; m_bdata = 0; m_addr = 0; m_wd = 0; m_we = 0;
      for (int cyc = 1; cyc <= 2000; cyc++) begin
         @(negedge clk);
         bus_ack_i = 0;
         bus_rdata_i = $urandom;
         exp_busy = m_act && cyc > m_g && cyc < m_a;
         exp_ifa  = m_act && cyc == m_a && !m_own;
         exp_dma  = m_act && cyc == m_a && m_own;
         if (m_act && cyc == m_a && m_to) m_err = 1;
         chk($sformatf("rnd%0d:bus_req", cyc), 32'(bus_req_o), 32'(exp_busy));
         chk($sformatf("rnd%0d:acks", cyc), {30'd0, if_ack_o, dm_ack_o}, {30'd0, exp_ifa, exp_dma});
         chk($sformatf("rnd%0d:err", cyc), 32'(err_o), 32'(m_err));
         chk($sformatf("rnd%0d:stall", cyc), 32'(stall_o),
             32'((if_req_i & ~exp_ifa) | (dm_req_i & ~exp_dma)));
         if (exp_busy) begin
            chk($sformatf("rnd%0d:bus_addr", cyc), bus_addr_o, m_addr);
            chk($sformatf("rnd%0d:bus_we", cyc), 32'(bus_we_o), 32'(m_we));
            if (m_own) chk($sformatf("rnd%0d:bus_wdata", cyc), bus_wdata_o, m_wd);
         end
         if (exp_ifa) chk($sformatf("rnd%0d:if_rdata", cyc), if_rdata_o, m_rd);
         if (exp_dma) chk($sformatf("rnd%0d:dm_rdata", cyc), dm_rdata_o, m_rd);
         // Bus side; for a timeout the late ack lands in RESP and must be ignored.
         if (m_act && cyc == m_g + 1 + m_L) begin
            bus_ack_i = 1;
            bus_rdata_i = m_bdata;
         end
         if (exp_ifa) if_req_i = 0;
         if (exp_dma) dm_req_i = 0;
         if (m_act && cyc == m_a) m_act = 0;
         if (!if_req_i && $urandom_range(0, 3) == 0) begin
            if_req_i = 1;
            if_addr_i = $urandom;
         end
         if (!dm_req_i && $urandom_range(0, 3) == 0) begin
            dm_req_i = 1;
            dm_we_i = 1'($urandom_range(0, 1));
            dm_addr_i = $urandom;
            dm_wdata_i = $urandom;
         end
         if (!m_act && cyc >= m_free && (if_req_i || dm_req_i)) begin
            m_own  = dm_req_i && (!if_req_i || !m_last);
            m_last = m_own;
            m_act  = 1;
            m_g    = cyc;
            m_L    = ($urandom_range(0, 7) == 0) ? $urandom_range(MAXW - 1, MAXW) : $urandom_range(0, 4);
            m_bdata = $urandom;
            m_to   = (m_L >= MAXW);
            m_a    = m_to ? cyc + 1 + MAXW : cyc + 2 + m_L;
            m_rd   = m_to ? 32'd0 : m_bdata;
            m_addr = m_own ? dm_addr_i : if_addr_i;
            m_we   = m_own & dm_we_i;
            m_wd   = dm_wdata_i;
            m_free = m_a + 1;
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
